// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: address and instruction types plus the
// fetch-queue entry payload.
package fetch_queue_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;
    typedef logic              bool;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
        bool   fault;
    } fq_entry_t;

    localparam int unsigned FQ_ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_ring_ptr.sv
// Ring pointer with an extra wrap bit; a plain binary increment over the full
// width wraps the index and toggles the wrap bit in one step.
module ring_ptr #(
    parameter int unsigned IDX_W = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clr,
    input  logic           i_inc,
    output logic [IDX_W:0] o_ptr
);

    logic [IDX_W:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + (IDX_W+1)'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode with single-cycle
// flush, occupancy count and an almost-full throttle hint.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AFULL_TH = DEPTH - 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  addr_t                  i_in_pc,
    input  inst_t                  i_in_inst,
    input  bool                    i_in_fault,
    output bool                    o_out_valid,
    input  logic                   i_out_ready,
    output addr_t                  o_out_pc,
    output inst_t                  o_out_inst,
    output bool                    o_out_fault,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_afull
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic             w_empty;
    logic             w_full;
    logic             w_enq;
    logic             w_deq;
    logic [PTR_W-1:0] w_count;
    fq_entry_t        w_head_entry;

    fq_entry_t r_mem [DEPTH];

    // Occupancy state is fully derived from the pointer pair.
    assign w_empty = (w_head == w_tail);
    assign w_full  = (w_head[IDX_W-1:0] == w_tail[IDX_W-1:0]) &&
                     (w_head[IDX_W] != w_tail[IDX_W]);

    assign w_enq = i_in_valid && !w_full && !i_flush;
    assign w_deq = !w_empty && i_out_ready && !i_flush;

    ring_ptr #(.IDX_W(IDX_W)) u_head_ptr (
        .i_clk   (i_clock),
        .i_reset (i_reset),
        .i_clr   (i_flush),
        .i_inc   (w_deq),
        .o_ptr   (w_head)
    );

    ring_ptr #(.IDX_W(IDX_W)) u_tail_ptr (
        .i_clk   (i_clock),
        .i_reset (i_reset),
        .i_clr   (i_flush),
        .i_inc   (w_enq),
        .o_ptr   (w_tail)
    );

    // Entry storage; contents survive flush and reset, only pointers clear.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_enq) begin
            r_mem[w_tail[IDX_W-1:0]] <= '{pc: i_in_pc, inst: i_in_inst, fault: i_in_fault};
        end
    end

    assign w_head_entry = w_empty ? '0 : r_mem[w_head[IDX_W-1:0]];
    assign w_count      = w_tail - w_head;

    assign o_in_ready  = !w_full;
    assign o_out_valid = !w_empty;
    assign o_out_pc    = w_head_entry.pc;
    assign o_out_inst  = w_head_entry.inst;
    assign o_out_fault = w_head_entry.fault;
    assign o_count     = w_count;
    assign o_afull     = 32'(w_count) >= AFULL_TH;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random
// traffic, checked against an occupancy-plus-queue reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic       clk;
    logic       rst;
    logic       fl;
    logic       v;
    addr_t      pc;
    inst_t      ins;
    logic       flt;
    logic       ordy;
    logic       o_in_ready;
    logic       o_out_valid;
    addr_t      o_out_pc;
    inst_t      o_out_inst;
    logic       o_out_fault;
    logic [CNT_W-1:0] o_count;
    logic       o_afull;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_flush     (fl),
        .i_in_valid  (v),
        .o_in_ready  (o_in_ready),
        .i_in_pc     (pc),
        .i_in_inst   (ins),
        .i_in_fault  (flt),
        .o_out_valid (o_out_valid),
        .i_out_ready (ordy),
        .o_out_pc    (o_out_pc),
        .o_out_inst  (o_out_inst),
        .o_out_fault (o_out_fault),
        .o_count     (o_count),
        .o_afull     (o_afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fq_entry_t exp_q[$];
    int        cnt = 0;
    bit        last_acc = 1'b0;
    bit        done = 1'b0;
    int        vectors = 0;
    int        miscompares = 0;

    // Reference model: occupancy plus program-order queue of accepted entries.
    always @(posedge clk) begin
        bit acc;
        bit dq;
        acc = v && !fl && !rst && (cnt < DEPTH);
        dq  = ordy && (cnt > 0) && !fl && !rst;
        last_acc = acc;
        if (rst || fl) begin
            cnt = 0;
            exp_q.delete();
        end else begin
            if (acc) exp_q.push_back('{pc: pc, inst: ins, fault: flt});
            cnt = cnt + int'(acc) - int'(dq);
        end
    end

    // Monitor: status every cycle, head data popped on each handshake.
    initial begin
        logic [CNT_W+2:0] exp_st;
        logic [CNT_W+2:0] act_st;
        fq_entry_t e;
        fq_entry_t a;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (done) break;
            exp_st = {CNT_W'(cnt), cnt < DEPTH, cnt > 0, cnt >= DEPTH - 2};
            act_st = {o_count, o_in_ready, o_out_valid, o_afull};
            a = '{pc: o_out_pc, inst: o_out_inst, fault: o_out_fault};
            vectors++;
            if (act_st !== exp_st) begin
                miscompares++;
                $display("FAIL status t=%0t {count,in_ready,out_valid,afull} got %h want %h",
                         $time, act_st, exp_st);
            end
            if (cnt == 0) begin
                vectors++;
                if (a !== '0) begin
                    miscompares++;
                    $display("FAIL empty_data t=%0t got %h want 0", $time, a);
                end
            end
            if (o_out_valid && ordy && !fl && !rst) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_out t=%0t got %h want no entry", $time, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL head_data t=%0t got %h want %h", $time, a, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input addr_t p, input inst_t i, input logic f);
        v = 1'b1; pc = p; ins = i; flt = f;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (last_acc) begin
                v = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout pc=%h got not accepted want accepted", p);
        v = 1'b0;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; fl = 1'b0; v = 1'b0; pc = '0; ins = '0; flt = 1'b0; ordy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // First entry visible the cycle after acceptance.
        push_wait(32'h0000_1000, 32'h0010_0093, 1'b0);
        tick();
        ordy = 1'b1; tick(); ordy = 1'b0;

        // Fill to full, hold a ninth entry, then release the consumer.
        for (int i = 0; i < DEPTH; i++)
            push_wait(32'h2000 + 32'(4 * i), $urandom, 1'b0);
        v = 1'b1; pc = 32'h2100; ins = $urandom; flt = 1'b0;
        tick(); tick(); tick();
        ordy = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 16 && !ok; k++) begin
            tick();
            ok = last_acc;
        end
        v = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL held_entry got not accepted want accepted");
        end
        for (int k = 0; k < 12; k++) tick();
        ordy = 1'b0;

        // Sustained enqueue+dequeue at occupancy 3 across two wraps.
        for (int i = 0; i < 3; i++) push_wait(32'h3000 + 32'(4 * i), $urandom, 1'b0);
        ordy = 1'b1; v = 1'b1;
        for (int i = 3; i < 23; i++) begin
            pc = 32'h3000 + 32'(4 * i); ins = $urandom; flt = 1'b0;
            tick();
        end
        v = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        ordy = 1'b0;

        // Flush with simultaneous enqueue and dequeue.
        for (int i = 0; i < 5; i++) push_wait(32'h4000 + 32'(4 * i), $urandom, 1'b0);
        v = 1'b1; pc = 32'hDEAD_0000; ins = $urandom; ordy = 1'b1; fl = 1'b1;
        tick();
        fl = 1'b0; pc = 32'h5000; ins = $urandom;
        tick();
        v = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        ordy = 1'b0;

        // Faulting fetch between ordinary neighbours.
        push_wait(32'h0000_0100, $urandom, 1'b0);
        push_wait(32'h8000_0000, $urandom, 1'b1);
        push_wait(32'h0000_0104, $urandom, 1'b0);
        ordy = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        ordy = 1'b0;

        // Reset during active traffic.
        for (int i = 0; i < 4; i++) push_wait(32'h6000 + 32'(4 * i), $urandom, 1'b0);
        v = 1'b1; pc = 32'h6100; ordy = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; v = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            if (!(v && !last_acc)) begin
                v   = ($urandom % 4) != 0;
                pc  = $urandom;
                ins = $urandom;
                flt = ($urandom % 8) == 0;
            end
            ordy = ($urandom % 3) != 0;
            fl   = ($urandom % 50) == 0;
            rst  = ($urandom % 200) == 0;
            tick();
        end
        v = 1'b0; fl = 1'b0; rst = 1'b0; ordy = 1'b0;
        tick();
        done = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
